// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM receive demultiplexer.
// Optional parity checking is enabled with the TDM_DEMUX_PARITY_EN macro.
package tdm_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NUM_CH_DEF = 4;
  localparam int ERR_W      = 8;
  localparam logic [ERR_W-1:0] ERR_SAT = '1;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  // Adds up to two error pulses in one cycle, clamping at ERR_SAT.
  function automatic logic [ERR_W-1:0] err_add(input logic [ERR_W-1:0] cnt,
                                               input logic [1:0]       n);
    logic [ERR_W:0] sum;
    sum = {1'b0, cnt} + {{(ERR_W-1){1'b0}}, n};
    if (sum[ERR_W]) return ERR_SAT;
    return sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM receiver: loads 1 on an accepted SOF,
// advances on data beats and wraps to 0 after the last slot.
module tdm_slot_ctr #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_one,
  input  logic            inc,
  output logic [CH_W-1:0] slot,
  output logic            is_last
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

  assign is_last = (slot == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load_one) begin
      slot <= CH_W'(1);
    end else if (inc) begin
      slot <= is_last ? '0 : slot + CH_W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux_rx.sv
// TDM receive demultiplexer: locks on SOF, buffers one frame in a shadow
// register and commits it atomically. Define TDM_DEMUX_PARITY_EN for parity.
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [DATA_W-1:0]        in_data,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic                     in_parity,
  output logic                     parity_err,
`endif
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     frame_valid,
  output logic                     locked,
  output logic                     sync_err,
  output logic [ERR_W-1:0]         err_cnt
);

  // Handshake: a beat is consumed whenever in_valid is high; there is no
  // backpressure. frame_valid/sync_err are single-cycle pulses, one cycle
  // after the beat that caused them.

  tdm_state_e              state, state_nx;
  logic [DATA_W-1:0]       shadow [NUM_CH];
  logic [CH_W-1:0]         slot;
  logic                    is_last;
  logic                    wr_en, load_one, inc, commit_beat, commit, err_sync;
  logic [CH_W-1:0]         wr_idx;
  logic [1:0]              err_n;
  logic [NUM_CH*DATA_W-1:0] frame_merged;

  tdm_slot_ctr #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_slot_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_one (load_one),
    .inc      (inc),
    .slot     (slot),
    .is_last  (is_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (in_valid) begin
      case (state)
        HUNT:    if (in_sof) state_nx = RECV;
        RECV:    if (!in_sof && slot == '0) state_nx = HUNT;
        default: state_nx = HUNT;
      endcase
    end
  end

  // An SOF always restarts the frame at slot 0; only a SOF seen mid-frame
  // is an error, and a non-SOF where slot 0 is due drops lock.
  always_comb begin
    wr_en       = 1'b0;
    load_one    = 1'b0;
    inc         = 1'b0;
    commit_beat = 1'b0;
    err_sync    = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_sof) begin
            wr_en    = 1'b1;
            load_one = 1'b1;
          end
        end
        RECV: begin
          if (in_sof) begin
            wr_en    = 1'b1;
            load_one = 1'b1;
            err_sync = (slot != '0);
          end else if (slot == '0) begin
            err_sync = 1'b1;
          end else begin
            wr_en       = 1'b1;
            inc         = 1'b1;
            commit_beat = is_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_idx = load_one ? '0 : slot;
  assign locked = (state == RECV);

  always_comb begin
    frame_merged = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      frame_merged[k*DATA_W +: DATA_W] = shadow[k];
    end
    frame_merged[(NUM_CH-1)*DATA_W +: DATA_W] = in_data;
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic bad_par, poison;

  assign bad_par = wr_en && ((^in_data) != in_parity);
  assign commit  = commit_beat && !(poison || bad_par);
  assign err_n   = {1'b0, err_sync} + {1'b0, bad_par};

  // A poisoned frame keeps counting slots but is never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poison     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= bad_par;
      if (load_one)  poison <= bad_par;
      else if (inc)  poison <= is_last ? 1'b0 : (poison || bad_par);
    end
  end
`else
  assign commit = commit_beat;
  assign err_n  = {1'b0, err_sync};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= '0;
      out_data    <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (wr_en) shadow[wr_idx] <= in_data;
      if (commit) out_data <= frame_merged;
      frame_valid <= commit;
      sync_err    <= err_sync;
      err_cnt     <= err_add(err_cnt, err_n);
    end
  end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// Scoreboard bench for tdm_demux_rx; parity tests run when TDM_DEMUX_PARITY_EN is defined.
module tb_tdm_demux_rx;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 4;
  localparam int FW     = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_sof;
  logic [DATA_W-1:0] in_data;
  logic [FW-1:0]     out_data;
  logic              frame_valid;
  logic              locked;
  logic              sync_err;
  logic [7:0]        err_cnt;
`ifdef TDM_DEMUX_PARITY_EN
  logic              in_parity;
  logic              parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [FW-1:0] exp_q[$];
  logic [7:0]    sync_q[$];
  logic [7:0]    par_q[$];
  logic [7:0]    exp_err_cnt = 8'd0;

  tdm_demux_rx #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_data     (in_data),
`ifdef TDM_DEMUX_PARITY_EN
    .in_parity   (in_parity),
    .parity_err  (parity_err),
`endif
    .out_data    (out_data),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .err_cnt     (err_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: act=still running req=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: act=%h req=%h", name, act, req);
    end
  endtask

  // Driver tasks: start and end at posedge+1
  task automatic beat(input logic sof, input logic [DATA_W-1:0] d, input logic bad_par = 1'b0);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
`ifdef TDM_DEMUX_PARITY_EN
    in_parity = (^d) ^ bad_par;
`else
    if (bad_par) $display("note: parity request ignored in this build");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [7:0] a3);
    exp_q.push_back({a3, a2, a1, a0});
    beat(1'b1, a0);
    beat(1'b0, a1);
    beat(1'b0, a2);
    beat(1'b0, a3);
  endtask

  function automatic logic [7:0] sat_next(input logic [7:0] c);
    return (c == 8'hFF) ? 8'hFF : c + 8'd1;
  endfunction

  task automatic expect_sync();
    exp_err_cnt = sat_next(exp_err_cnt);
    sync_q.push_back(exp_err_cnt);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid && sync_err) check("fv_and_serr", 1, 0);
      if (frame_valid) begin
        if (exp_q.size() == 0) check("unexpected_frame_valid", FW'(out_data), FW'(0) ^ ~FW'(0) ^ FW'(0) ^ FW'(1'b1) & 0 | FW'(out_data) + 1);
        else check("frame", out_data, exp_q.pop_front());
      end
      if (sync_err) begin
        if (sync_q.size() == 0) check("unexpected_sync_err", FW'(err_cnt), FW'(err_cnt) + 1);
        else check("sync_err_cnt", FW'(err_cnt), FW'(sync_q.pop_front()));
      end
`ifdef TDM_DEMUX_PARITY_EN
      if (parity_err) begin
        if (par_q.size() == 0) check("unexpected_parity_err", FW'(err_cnt), FW'(err_cnt) + 1);
        else check("parity_err_cnt", FW'(err_cnt), FW'(par_q.pop_front()));
      end
`endif
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
`ifdef TDM_DEMUX_PARITY_EN
    in_parity = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", out_data, '0);
    check("rst_frame_valid", FW'(frame_valid), '0);
    check("rst_locked", FW'(locked), '0);
    check("rst_sync_err", FW'(sync_err), '0);
    check("rst_err_cnt", FW'(err_cnt), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single frame, latency 1 from last beat
    send_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    check("t1_fv", FW'(frame_valid), FW'(1));
    check("t1_data", out_data, 32'hA3A2A1A0);
    check("t1_locked", FW'(locked), FW'(1));
    idle(1);
    check("t1_fv_pulse", FW'(frame_valid), '0);

    // 2: gap inside a frame, then a back-to-back frame
    exp_q.push_back(32'hB3B2B1B0);
    beat(1'b1, 8'hB0);
    beat(1'b0, 8'hB1);
    idle(3);
    beat(1'b0, 8'hB2);
    beat(1'b0, 8'hB3);
    send_frame(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    idle(2);

    // 3: early SOF discards the partial frame
    beat(1'b1, 8'h11);
    beat(1'b0, 8'h22);
    expect_sync();
    send_frame(8'h33, 8'h44, 8'h55, 8'h66);
    idle(1);
    check("t3_data", out_data, 32'h66554433);
    check("t3_err_cnt", FW'(err_cnt), FW'(1));

    // 4: non-SOF where slot 0 is due drops lock, then relock
    expect_sync();
    beat(1'b0, 8'h77);
    check("t4_locked", FW'(locked), '0);
    check("t4_data_kept", out_data, 32'h66554433);
    send_frame(8'h81, 8'h82, 8'h83, 8'h84);
    idle(1);
    check("t4_relocked", FW'(locked), FW'(1));

    // 5: asynchronous reset mid-frame
    beat(1'b1, 8'hD0);
    beat(1'b0, 8'hD1);
    beat(1'b0, 8'hD2);
    rst_n = 1'b0;
    #1;
    check("t5_out_data", out_data, '0);
    check("t5_locked", FW'(locked), '0);
    check("t5_err_cnt", FW'(err_cnt), '0);
    check("t5_fv", FW'(frame_valid), '0);
    exp_err_cnt = 8'd0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b0, 8'h12);
    beat(1'b0, 8'h34);
    check("t5_hunt_locked", FW'(locked), '0);
    check("t5_hunt_err_cnt", FW'(err_cnt), '0);
    send_frame(8'hE0, 8'hE1, 8'hE2, 8'hE3);
    idle(1);

`ifdef TDM_DEMUX_PARITY_EN
    // 6: bad parity on slot 1 poisons the frame but keeps lock
    exp_err_cnt = sat_next(exp_err_cnt);
    par_q.push_back(exp_err_cnt);
    beat(1'b1, 8'hF0);
    beat(1'b0, 8'hF1, 1'b1);
    beat(1'b0, 8'hF2);
    beat(1'b0, 8'hF3);
    check("t6_no_commit", out_data, 32'hE3E2E1E0);
    check("t6_locked", FW'(locked), FW'(1));
    send_frame(8'h5A, 8'hA5, 8'h3C, 8'hC3);
    idle(1);
`endif

    // Saturation: a run of SOFs, each one after the first is an early SOF
    for (int i = 0; i < 300; i++) begin
      if (i > 0) expect_sync();
      beat(1'b1, 8'(i));
    end
    exp_q.push_back({8'h93, 8'h92, 8'h91, 8'(299)});
    beat(1'b0, 8'h91);
    beat(1'b0, 8'h92);
    beat(1'b0, 8'h93);
    idle(1);
    check("sat_err_cnt", FW'(err_cnt), FW'(8'hFF));

    idle(3);
    check("left_frames", FW'(exp_q.size()), '0);
    check("left_sync", FW'(sync_q.size()), '0);
    check("left_parity", FW'(par_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_rx.md
Name: tdm_demux_rx

Overview:
- Receive end of a time-division multiplexed link. A single data lane carries NUM_CH channel words per frame, one slot per beat, with slot 0 marked by in_sof.
- The block locks onto frame boundaries and buffers one frame in a shadow register. It commits the whole frame atomically to per-channel outputs.
- Sits after the link transmitter's serializing mux and feeds the channel consumers (the 1:N demultiplex side of the channel fabric).

Parameters:
- DATA_W, 8, width of one channel word.
- NUM_CH, 4, slots per frame (>=2).
- CH_W, $clog2(NUM_CH), slot index width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  beat present on in_data this cycle.
- in_sof  input  1  beat is slot 0 of a frame (qualified by in_valid).
- in_data  input  DATA_W  slot word.
- out_data  output  NUM_CH*DATA_W  committed frame; channel k at bits [k*DATA_W +: DATA_W].
- frame_valid  output  1  one-cycle pulse when out_data was updated this cycle.
- locked  output  1  FSM in RECV.
- sync_err  output  1  one-cycle pulse on a framing violation.
- err_cnt  output  8  saturating count of sync_err (and parity_err if enabled).

Behaviour:
- Reset values (async assert, sync release): out_data=0, frame_valid=0, locked=0, sync_err=0, err_cnt=0, slot=0, shadow=0, state=HUNT.
- States:
  - HUNT: in_valid&in_sof -> shadow[0]<=in_data, slot<=1, go to RECV. in_valid&!in_sof -> beat dropped, no error.
  - RECV: in_valid&!in_sof -> shadow[slot]<=in_data, slot<=slot+1.
  - RECV, slot==NUM_CH-1 beat: write the final word, then out_data<=shadow with the final word merged. frame_valid=1 next cycle (latency 1 from last beat). slot wraps to 0 and state stays RECV.
  - RECV, slot==0, in_valid&in_sof: normal next frame, stored as slot 0.
  - RECV, slot==0, in_valid&!in_sof: sync_err pulse, beat dropped, go to HUNT.
  - RECV, slot!=0, in_valid&in_sof (early SOF): sync_err pulse. The partial frame is discarded (out_data unchanged, no frame_valid). The beat is taken as slot 0 of a new frame, slot<=1, state stays RECV.
- in_valid=0: no state change (gaps between beats allowed, any length).
- frame_valid and sync_err are never both asserted for the same beat.
- err_cnt increments on each error pulse and saturates at 8'hFF.
- Reset mid-frame: shadow and partial frame are lost, and out_data returns to 0.
- Inputs at x/z are not handled in RTL; the bench keeps inputs at known values.

Optional Feature:
- Macro: TDM_DEMUX_PARITY_EN.
- With the macro: extra port in_parity (input, 1), the even parity over in_data of each beat. Mismatch on any accepted beat -> parity_err (output, 1) pulses the cycle after that beat and increments err_cnt. The current frame is poisoned: it completes slot counting but is not committed (no frame_valid), and lock is kept.
- Without the macro: neither port exists and no parity logic is present.

Decomposition:
- Package tdm_pkg:
  - state enum {HUNT, RECV}.
  - DATA_W/NUM_CH defaults.
  - Error-counter width 8 and saturation constant.
- Sub-module tdm_slot_ctr: the slot counter with wrap at NUM_CH-1, sync-load to 1 on SOF, and an is_last flag.

Test Plan:
1. Reset, then frame SOF A0,A1,A2,A3 back-to-back -> one cycle after A3: out_data={A3,A2,A1,A0}, frame_valid=1 for 1 cycle, locked=1.
2. Two frames, with 3 idle cycles inserted between slots 1 and 2 of the first -> two frame_valid pulses with correct words each; no sync_err.
3. Locked; SOF 11,22, then SOF 33,44,55,66 -> sync_err pulse on the second SOF. The first partial frame is not committed; out_data={66,55,44,33}; err_cnt=1.
4. After a full frame, non-SOF beat 77 -> sync_err, locked=0, beat dropped. Next SOF frame relocks and commits normally.
5. Assert rst_n=0 after slot 2 of a frame -> all outputs 0 immediately. Post-reset non-SOF beats are ignored with no error until SOF.
6. With TDM_DEMUX_PARITY_EN: wrong parity on slot 1 -> parity_err pulse, no frame_valid for that frame, and the next clean frame commits.
